// File: rtl/bit_scatter_pkg.sv
// Shared widths and FSM encoding for the 64-position bit scatter path.
// Optional feature macro used by importers: BIT_SCATTER_DUP_DETECT_EN.
package bit_scatter_pkg;

    localparam int unsigned SEL_W  = 6;
    localparam int unsigned N_BITS = 64;
    localparam int unsigned CNT_W  = SEL_W + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/bit_scatter_64_if.sv
// Handshake bundle for bit_scatter_64.
//   write side : in_valid, in_ready, in_select, in_bit, flush
//   word side  : out_valid, out_ready, out_word, out_mask, out_count
//   dup_err    : only present with BIT_SCATTER_DUP_DETECT_EN defined
// master = producer/consumer side, slave = scatter block.
interface bit_scatter_64_if;
    import bit_scatter_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_select;
    logic              in_bit;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_word;
    logic [N_BITS-1:0] out_mask;
    logic [CNT_W-1:0]  out_count;
`ifdef BIT_SCATTER_DUP_DETECT_EN
    logic              dup_err;
`endif

    modport master (
        output in_valid, in_select, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_word, out_mask, out_count
`ifdef BIT_SCATTER_DUP_DETECT_EN
        , input dup_err
`endif
    );

    modport slave (
        input  in_valid, in_select, in_bit, flush, out_ready,
        output in_ready, out_valid, out_word, out_mask, out_count
`ifdef BIT_SCATTER_DUP_DETECT_EN
        , output dup_err
`endif
    );

endinterface

// File: rtl/demux_64_1_bit.sv
// Combinational 6-to-64 one-hot decoder with enable.
//   en     : decode enable (write accept)
//   sel    : position to select
//   onehot : per-position write enables, all zero when en=0
module demux_64_1_bit
    import bit_scatter_pkg::*;
(
    input  logic              en,
    input  logic [SEL_W-1:0]  sel,
    output logic [N_BITS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/bit_scatter_64.sv
// Assembles single-bit writes into a 64-bit word and releases it when every
// position is filled or on flush.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : write handshake in, assembled word handshake out
// Macro BIT_SCATTER_DUP_DETECT_EN: first write wins and dup_err flags repeats.
module bit_scatter_64
    import bit_scatter_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    bit_scatter_64_if.slave bus
);

    state_t            state_q;
    logic [N_BITS-1:0] word_q;
    logic [N_BITS-1:0] mask_q;
    logic [CNT_W-1:0]  count_q;

    logic              ready;
    logic              accept;
    logic              new_pos;
    logic [N_BITS-1:0] sel_hot;
    logic [N_BITS-1:0] we;
    logic [N_BITS-1:0] word_d;
    logic [N_BITS-1:0] mask_d;
    logic [CNT_W-1:0]  count_d;
    logic              full;
    logic              release_go;

    // Accepting only in FILL and never while reset is asserted.
    assign ready  = (state_q == FILL) & reset_n;
    assign accept = bus.in_valid & ready;

    demux_64_1_bit u_demux (
        .en     (accept),
        .sel    (bus.in_select),
        .onehot (sel_hot)
    );

`ifdef BIT_SCATTER_DUP_DETECT_EN
    logic dup_q;
    logic dup_hit;
    // Repeat writes are dropped so the first value sticks.
    assign we      = sel_hot & ~mask_q;
    assign dup_hit = accept & mask_q[bus.in_select];
    assign bus.dup_err = dup_q;
`else
    assign we = sel_hot;
`endif

    // Next word/mask/count including this cycle's accept.
    always_comb begin
        new_pos    = accept & ~mask_q[bus.in_select];
        word_d     = (word_q & ~we) | (we & {N_BITS{bus.in_bit}});
        mask_d     = mask_q | we;
        count_d    = count_q + CNT_W'(new_pos);
        full       = (count_d == CNT_W'(N_BITS));
        release_go = full | (bus.flush & (count_d != '0));
    end

    // FSM plus word/mask/count registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= FILL;
            word_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
`ifdef BIT_SCATTER_DUP_DETECT_EN
            dup_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    word_q  <= word_d;
                    mask_q  <= mask_d;
                    count_q <= count_d;
`ifdef BIT_SCATTER_DUP_DETECT_EN
                    dup_q   <= dup_q | dup_hit;
`endif
                    if (release_go) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= FILL;
                        word_q  <= '0;
                        mask_q  <= '0;
                        count_q <= '0;
`ifdef BIT_SCATTER_DUP_DETECT_EN
                        dup_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_word  = word_q;
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_bit_scatter_64.sv
// Self-checking bench for bit_scatter_64: directed scenarios plus random
// traffic against a per-position reference model.
module tb_bit_scatter_64;
    import bit_scatter_pkg::*;

    logic clock;
    logic reset_n;

    bit_scatter_64_if bus ();

    bit_scatter_64 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: one entry per bit position.
    bit m_val  [N_BITS];
    bit m_fill [N_BITS];
    bit m_hold;
    bit m_dup;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < N_BITS; i++) n += int'(m_fill[i]);
        return n;
    endfunction

    function automatic logic [63:0] m_word();
        logic [63:0] w = '0;
        for (int i = 0; i < N_BITS; i++) w[i] = m_val[i];
        return w;
    endfunction

    function automatic logic [63:0] m_mask();
        logic [63:0] w = '0;
        for (int i = 0; i < N_BITS; i++) w[i] = m_fill[i];
        return w;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N_BITS; i++) begin
            m_val[i]  = 1'b0;
            m_fill[i] = 1'b0;
        end
        m_hold = 1'b0;
        m_dup  = 1'b0;
    endtask

    // Apply one clock of stimulus to DUT and model, then compare everything.
    task automatic cycle(input bit rst, input bit v, input int sel, input bit b,
                         input bit fl, input bit ordy);
        reset_n       = rst;
        bus.in_valid  = v;
        bus.in_select = SEL_W'(sel);
        bus.in_bit    = b;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(posedge clock);
        if (!rst) begin
            m_clear();
        end else if (!m_hold) begin
            if (v) begin
`ifdef BIT_SCATTER_DUP_DETECT_EN
                if (m_fill[sel]) m_dup = 1'b1;
                else begin
                    m_val[sel]  = b;
                    m_fill[sel] = 1'b1;
                end
`else
                m_val[sel]  = b;
                m_fill[sel] = 1'b1;
`endif
            end
            if (m_count() == N_BITS || (fl && m_count() > 0)) m_hold = 1'b1;
        end else if (ordy) begin
            m_clear();
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
        chk("out_word",  bus.out_word, m_word());
        chk("out_mask",  bus.out_mask, m_mask());
        chk("out_count", 64'(bus.out_count), 64'(m_count()));
        chk("in_ready",  64'(bus.in_ready), 64'(!m_hold && reset_n));
`ifdef BIT_SCATTER_DUP_DETECT_EN
        chk("dup_err",   64'(bus.dup_err), 64'(m_dup));
`endif
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, ordy);
    endtask

    logic [63:0] held;

    initial begin
        m_clear();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_select = '0;
        bus.in_bit    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, i, 1'b1, 1'b1, 1'b0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_word",  bus.out_word, 64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 64'(bus.in_ready), 64'd1);

        // Full fill, bit value = lsb of select.
        for (int i = 0; i < N_BITS; i++) begin
            chk("fill_pending", 64'(bus.out_valid), 64'd0);
            cycle(1'b1, 1'b1, i, i[0], 1'b0, 1'b0);
        end
        chk("full_valid", 64'(bus.out_valid), 64'd1);
        chk("full_word",  bus.out_word, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("full_mask",  bus.out_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("full_count", 64'(bus.out_count), 64'd64);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        idle(1'b1);
        chk("full_rel_mask", bus.out_mask, 64'd0);

        // Flush with a same-cycle write.
        cycle(1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_word",  bus.out_word, 64'h224);
        chk("flush_mask",  bus.out_mask, 64'h224);
        chk("flush_count", 64'(bus.out_count), 64'd3);

        // Backpressure: contents stable, writes and flushes ignored.
        held = bus.out_word;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 40 + i, 1'b1, 1'b1, 1'b0);
            chk("bp_word", bus.out_word, held);
        end
        idle(1'b1);
        chk("bp_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_mask",  bus.out_mask, 64'd0);

        // Flush with nothing collected emits nothing.
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("empty_flush", 64'(bus.out_valid), 64'd0);

        // Rewrite of the same position.
        cycle(1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("rw_count", 64'(bus.out_count), 64'd1);
`ifdef BIT_SCATTER_DUP_DETECT_EN
        chk("rw_word", bus.out_word, 64'h80);
        chk("rw_dup",  64'(bus.dup_err), 64'd1);
`else
        chk("rw_word", bus.out_word, 64'h0);
`endif
        idle(1'b1);

        // Reset after 30 writes, then a clean full word.
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, i, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_mask",  bus.out_mask, 64'd0);
        chk("mid_rst_count", 64'(bus.out_count), 64'd0);
        for (int i = 0; i < N_BITS; i++) cycle(1'b1, 1'b1, 63 - i, 1'($urandom), 1'b0, 1'b0);
        chk("clean_valid", 64'(bus.out_valid), 64'd1);
        chk("clean_mask",  bus.out_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1'b1);

        // Random traffic: frequent flushes, then mostly full words.
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 63)), 1'($urandom),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 1500; i++)
            cycle(1'b1, 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 63)), 1'($urandom),
                  1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 2) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
